seg_scan_capture: RTL and testbench

Receive-side companion to the multiplexed 7-segment display driver: samples a scanned segment/select bus (six digits, active-low select, active-low segments), decodes each digit's pattern back to a hex nibble plus decimal point, and publishes a complete 24-bit value once all six digits are captured cleanly. It sits on the board-test and loopback path, reading the display pins produced by the hex/BCD scan drivers, or an external module using the same bus. It reports frame completion, invalid patterns and loss of scanning.

---
 rtl/seg_scan_capture.sv | 164 ++++++++++++++++
 tb/tb_seg_scan_capture.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a scanned 7-segment bus and rebuilds the displayed 24-bit value.
// Define SEG_SCAN_CAPTURE_DOT_EN to capture decimal points into oDot.
module seg_scan_capture #(
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 1048576
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [7:0]  iSeg,
    input  logic [5:0]  iSel,
    output logic [23:0] oNum,
    output logic [5:0]  oDot,
    output logic        oValid,
    output logic        oErr,
    output logic        oStale
);

    localparam logic [15:0] SETTLE_V  = 16'(SETTLE);
    localparam logic [20:0] TIMEOUT_V = 21'(TIMEOUT);
    localparam logic [6:0]  SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [7:0]  segMeta, sSeg;
    logic [5:0]  selMeta, sSel;
    logic [5:0]  selLow;
    logic        oneLow;
    logic        dwellClr;
    logic        sampleNow;
    logic [15:0] dwell;
    logic [2:0]  digit;
    logic [6:0]  pattern;
    logic        patOk;
    logic [3:0]  nib;
    logic [5:0]  mask;
    logic [5:0]  nextMask;
    logic        bad;
    logic        frameDone;
    logic        publish;
    logic [23:0] shadowNum;
    logic [23:0] nextNum;
    logic [20:0] staleCnt;

    // Two-flop synchronizers; idle state is the blank bus (all ones)
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            segMeta <= '1;
            sSeg    <= '1;
            selMeta <= '1;
            sSel    <= '1;
        end else begin
            segMeta <= iSeg;
            sSeg    <= segMeta;
            selMeta <= iSel;
            sSel    <= selMeta;
        end
    end

    // Select qualification: exactly one digit low, not about to change, sample at end of settle
    always_comb begin
        selLow    = ~sSel;
        oneLow    = |selLow && ~|(selLow & (selLow - 6'd1));
        dwellClr  = (selMeta != sSel) || !oneLow;
        sampleNow = !dwellClr && (dwell == SETTLE_V - 16'd1);
    end

    // Active-low select bit k addresses digit 5-k
    always_comb begin
        digit = 3'd0;
        for (int k = 0; k < 6; k++)
            if (selLow[k]) digit = 3'(5 - k);
    end

    // Segment pattern back to a hex nibble; no match flags an invalid pattern
    always_comb begin
        pattern = ~sSeg[6:0];
        patOk   = 1'b0;
        nib     = 4'd0;
        for (int n = 0; n < 16; n++)
            if (pattern == SEG_TABLE[n]) begin
                patOk = 1'b1;
                nib   = 4'(n);
            end
    end

    // Frame bookkeeping: shadow contents and completion after this sample
    always_comb begin
        nextMask  = mask | (6'b000001 << digit);
        frameDone = sampleNow && (nextMask == 6'h3F);
        publish   = frameDone && !bad && patOk;
        nextNum   = shadowNum;
        if (sampleNow && patOk) nextNum[{digit, 2'b00} +: 4] = nib;
    end

    // Dwell counter: restarts on any select change or invalid select, saturates at SETTLE
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) dwell <= '0;
        else if (dwellClr) dwell <= '0;
        else if (dwell != SETTLE_V) dwell <= dwell + 16'd1;
    end

    // Shadow capture with per-frame mask and sticky bad flag
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            shadowNum <= '0;
            mask      <= '0;
            bad       <= 1'b0;
        end else if (sampleNow) begin
            shadowNum <= nextNum;
            mask      <= frameDone ? 6'h00 : nextMask;
            bad       <= frameDone ? 1'b0 : (bad || !patOk);
        end
    end

    // Published value and event pulses
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oNum   <= '0;
            oValid <= 1'b0;
            oErr   <= 1'b0;
        end else begin
            oValid <= publish;
            oErr   <= sampleNow && !patOk;
            if (publish) oNum <= nextNum;
        end
    end

`ifdef SEG_SCAN_CAPTURE_DOT_EN
    logic [5:0] shadowDot;
    logic [5:0] nextDot;

    // Decimal point of the sampled digit joins the shadow frame
    always_comb begin
        nextDot = shadowDot;
        if (sampleNow && patOk) nextDot[digit] = ~sSeg[7];
    end

    // Dot shadow and its published copy
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            shadowDot <= '0;
            oDot      <= '0;
        end else begin
            if (sampleNow) shadowDot <= nextDot;
            if (publish) oDot <= nextDot;
        end
    end
`else
    logic unusedDot;
    assign unusedDot = sSeg[7];
    assign oDot      = '0;
`endif

    // Stale watchdog: counts cycles since the last publish, saturating at TIMEOUT
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) staleCnt <= '0;
        else if (publish) staleCnt <= '0;
        else if (staleCnt != TIMEOUT_V) staleCnt <= staleCnt + 21'd1;
    end

    assign oStale = (staleCnt == TIMEOUT_V);

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed and randomized scan frames checked against a frame-level model.
module tb_seg_scan_capture;

    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 1000;
    localparam int LAT     = SETTLE + 2;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [7:0]  iSeg = 8'hFF;
    logic [5:0]  iSel = 6'h3F;
    logic [23:0] oNum;
    logic [5:0]  oDot;
    logic        oValid, oErr, oStale;

    int tests = 0, fails = 0;
    int cyc = 0, validCnt = 0, errCnt = 0, validCyc = 0, errCyc = 0;
    logic        staleAtValid = 1'b0;
    logic [23:0] expNum = '0;
    logic [5:0]  expDot = '0;

    seg_scan_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSeg(iSeg), .iSel(iSel),
        .oNum(oNum), .oDot(oDot), .oValid(oValid), .oErr(oErr), .oStale(oStale)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc <= cyc + 1;

    // Event monitor sampled away from the active edge
    always @(negedge iCLK) begin
        if (oValid) begin
            validCnt++;
            validCyc = cyc;
            staleAtValid = oStale;
        end
        if (oErr) begin
            errCnt++;
            errCyc = cyc;
        end
    end

    function automatic logic isCode(input logic [6:0] p);
        for (int n = 0; n < 16; n++) if (SEG_TAB[n] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [6:0] badPattern(input bit rnd);
        logic [6:0] p = 7'h00;
        if (rnd) begin
            p = 7'($urandom);
            while (isCode(p)) p = 7'($urandom);
        end
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic driveDigit(input int d, input logic [6:0] pat, input logic dp, input int dwell, output int at);
        logic [5:0] one = 6'b000001;
        @(posedge iCLK);
        #1;
        iSel = ~(one << (5 - d));
        iSeg = ~{dp, pat};
        at = cyc;
        repeat (dwell) @(posedge iCLK);
        #1;
        iSel = 6'h3F;
        iSeg = 8'hFF;
        repeat (3) @(posedge iCLK);
    endtask

    task automatic scanFrame(input string tag, input logic [23:0] val, input logic [5:0] dots,
                             input logic [5:0] badMask, input bit rnd);
        int order [6];
        int at = 0, lastAt = 0, lastBadAt = 0;
        int v0 = validCnt, e0 = errCnt;
        for (int i = 0; i < 6; i++) order[i] = i;
        if (rnd)
            for (int i = 5; i > 0; i--) begin
                int j = int'($urandom_range(i, 0));
                int t = order[i];
                order[i] = order[j];
                order[j] = t;
            end
        for (int i = 0; i < 6; i++) begin
            int d = order[i];
            logic [6:0] pat = badMask[d] ? badPattern(rnd) : SEG_TAB[val[4*d +: 4]];
            driveDigit(d, pat, dots[d], rnd ? int'($urandom_range(60, 25)) : 100, at);
            lastAt = at;
            if (badMask[d]) lastBadAt = at;
        end
        repeat (4) @(posedge iCLK);
        if (badMask == 6'd0) begin
            expNum = val;
`ifdef SEG_SCAN_CAPTURE_DOT_EN
            expDot = dots;
`endif
        end
        check({tag, ".valid"}, 32'(validCnt - v0), {31'd0, badMask == 6'd0});
        check({tag, ".err"}, 32'(errCnt - e0), 32'($countones(badMask)));
        check({tag, ".num"}, {8'd0, oNum}, {8'd0, expNum});
        check({tag, ".dot"}, {26'd0, oDot}, {26'd0, expDot});
        if (badMask == 6'd0) check({tag, ".vlat"}, 32'(validCyc - lastAt), LAT);
        else check({tag, ".elat"}, 32'(errCyc - lastBadAt), LAT);
    endtask

    initial begin
        int at = 0;
        int v0 = 0;
        int e0 = 0;
        logic [5:0] rdots;
        logic [5:0] rbad;
        repeat (3) @(posedge iCLK);
        #1;
        check("rst.num", {8'd0, oNum}, 32'd0);
        check("rst.dot", {26'd0, oDot}, 32'd0);
        check("rst.valid", {31'd0, oValid}, 32'd0);
        check("rst.err", {31'd0, oErr}, 32'd0);
        check("rst.stale", {31'd0, oStale}, 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;

        scanFrame("basic", 24'h12AB3F, 6'b000000, 6'b000000, 1'b0);
        scanFrame("dot3", 24'h12AB3F, 6'b001000, 6'b000000, 1'b0);
        scanFrame("blank2", 24'h654321, 6'b000000, 6'b000100, 1'b0);
        scanFrame("clean", 24'h0FEDCB, 6'b100001, 6'b000000, 1'b0);

        e0 = errCnt;
        v0 = validCnt;
        @(posedge iCLK);
        #1;
        iSel = 6'b110101;
        iSeg = 8'hFF;
        repeat (50) @(posedge iCLK);
        #1;
        iSel = 6'b111011;
        repeat (SETTLE - 1) @(posedge iCLK);
        #1;
        iSel = 6'h3F;
        repeat (6) @(posedge iCLK);
        check("glitch.err", 32'(errCnt - e0), 32'd0);
        check("glitch.valid", 32'(validCnt - v0), 32'd0);
        scanFrame("postglitch", 24'h31C9E7, 6'b010010, 6'b000000, 1'b0);

        for (int f = 0; f < 6; f++) begin
            rdots = 6'($urandom);
            rbad = ($urandom_range(2, 0) == 0) ? (6'b000001 << $urandom_range(5, 0)) : 6'd0;
            scanFrame("rand", 24'($urandom), rdots, rbad, 1'b1);
        end

        scanFrame("prestale", 24'hA5C3E1, 6'b000000, 6'b000000, 1'b0);
        iSel = 6'h3F;
        while (cyc < validCyc + TIMEOUT - 1) @(negedge iCLK);
        check("stale.before", {31'd0, oStale}, 32'd0);
        @(negedge iCLK);
        check("stale.at", {31'd0, oStale}, 32'd1);
        check("stale.delay", 32'(cyc - validCyc), TIMEOUT);
        repeat (30) @(negedge iCLK);
        check("stale.hold", {31'd0, oStale}, 32'd1);
        scanFrame("resume", 24'h777000, 6'b000000, 6'b000000, 1'b0);
        check("resume.staleAtValid", {31'd0, staleAtValid}, 32'd0);
        check("resume.stale", {31'd0, oStale}, 32'd0);

        for (int d = 2; d < 6; d++) driveDigit(d, SEG_TAB[4'(d + 8)], 1'b0, 40, at);
        @(posedge iCLK);
        #3;
        iRST = 1'b1;
        #1;
        check("mrst.num", {8'd0, oNum}, 32'd0);
        check("mrst.dot", {26'd0, oDot}, 32'd0);
        check("mrst.valid", {31'd0, oValid}, 32'd0);
        check("mrst.stale", {31'd0, oStale}, 32'd0);
        expNum = '0;
        expDot = '0;
        @(negedge iCLK);
        iRST = 1'b0;
        v0 = validCnt;
        for (int d = 0; d < 5; d++) driveDigit(d, SEG_TAB[4'(d + 4)], 1'b0, 40, at);
        check("mrst.partial", 32'(validCnt - v0), 32'd0);
        check("mrst.partialNum", {8'd0, oNum}, 32'd0);
        driveDigit(5, SEG_TAB[4'd9], 1'b0, 40, at);
        repeat (4) @(posedge iCLK);
        check("mrst.full", 32'(validCnt - v0), 32'd1);
        check("mrst.num2", {8'd0, oNum}, 32'h00987654);
        check("mrst.vlat", 32'(validCyc - at), LAT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
